// File: rtl/input_cmd_arbiter_if.sv
// Command-port bundle shared by the UART/local command sources, the arbiter and the gameplay consumer.
interface input_cmd_arbiter_if;
    logic [7:0] uart_data_in;
    logic       uart_valid_in;
    logic [7:0] local_cmd_in;
    logic       local_valid_in;
    logic [7:0] cmd_out;
    logic       cmd_valid_out;
    logic       cmd_ready_in;
    logic       src_out;
    logic       fifo_full_out;
    logic [7:0] err_count_out;

    modport slave (
        input  uart_data_in, uart_valid_in, local_cmd_in, local_valid_in, cmd_ready_in,
        output cmd_out, cmd_valid_out, src_out, fifo_full_out, err_count_out
    );

    modport master (
        output uart_data_in, uart_valid_in, local_cmd_in, local_valid_in, cmd_ready_in,
        input  cmd_out, cmd_valid_out, src_out, fifo_full_out, err_count_out
    );
endinterface

// File: rtl/input_cmd_arbiter.sv
// Parses HDR/CMD/CHK UART frames into a small FIFO and round-robins them with a one-entry
// local command slot onto a single valid/ready command port.
module input_cmd_arbiter #(
    parameter logic [7:0]  HDR_BYTE       = 8'hA5,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 742500
) (
    input logic                clk_in,
    input logic                rst_in,
    input_cmd_arbiter_if.slave bus
);
    localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CMD = 2'd1,
        WAIT_CHK = 2'd2
    } parse_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd);
        return HDR_BYTE ^ cmd;
    endfunction

    function automatic logic [7:0] err_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    parse_state_t  parse_state_r, parse_state_s;
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [7:0]    cmd_latch_r;
    logic          frame_good_s, parse_err_s;

    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] fifo_cnt_r, fifo_cnt_s;
    logic          fifo_full_r;
    logic          push_s, drop_s;

    logic          pend_r;
    logic [7:0]    pend_cmd_r;
    logic          lost_local_s;

    logic          out_valid_r, out_src_r, rr_local_r;
    logic [7:0]    out_cmd_r;
    logic          load_s, grant_uart_s, grant_local_s;

    logic [7:0]    err_r;
    logic [1:0]    err_inc_s;

    // Parser next-state: frame tracking, checksum test and inter-byte timeout.
    always_comb begin
        parse_state_s = parse_state_r;
        tmo_cnt_s     = tmo_cnt_r;
        frame_good_s  = 1'b0;
        parse_err_s   = 1'b0;
        case (parse_state_r)
            IDLE: begin
                tmo_cnt_s = TW'(0);
                if (bus.uart_valid_in && (bus.uart_data_in == HDR_BYTE)) begin
                    parse_state_s = WAIT_CMD;
                end else begin
                    parse_state_s = IDLE;
                end
            end
            WAIT_CMD, WAIT_CHK: begin
                if (bus.uart_valid_in) begin
                    tmo_cnt_s = TW'(0);
                    if (parse_state_r == WAIT_CMD) begin
                        parse_state_s = WAIT_CHK;
                    end else begin
                        parse_state_s = IDLE;
                        if (bus.uart_data_in == frame_chk(cmd_latch_r)) begin
                            frame_good_s = 1'b1;
                        end else begin
                            parse_err_s = 1'b1;
                        end
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    parse_err_s   = 1'b1;
                    parse_state_s = IDLE;
                    tmo_cnt_s     = TW'(0);
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TW'(1);
                end
            end
            default: begin
                parse_state_s = IDLE;
                tmo_cnt_s     = TW'(0);
            end
        endcase
    end

    // Parser state, timeout counter and CMD byte latch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            parse_state_r <= IDLE;
            tmo_cnt_r     <= TW'(0);
            cmd_latch_r   <= 8'h00;
        end else begin
            parse_state_r <= parse_state_s;
            tmo_cnt_r     <= tmo_cnt_s;
            if ((parse_state_r == WAIT_CMD) && bus.uart_valid_in) begin
                cmd_latch_r <= bus.uart_data_in;
            end
        end
    end

    // Arbitration: on a tie the source not granted last wins; a full FIFO still accepts if popped.
    always_comb begin
        load_s        = !out_valid_r || bus.cmd_ready_in;
        grant_uart_s  = 1'b0;
        grant_local_s = 1'b0;
        if (load_s) begin
            if ((fifo_cnt_r != CW'(0)) && pend_r) begin
                grant_uart_s  = !rr_local_r;
                grant_local_s = rr_local_r;
            end else begin
                grant_uart_s  = (fifo_cnt_r != CW'(0));
                grant_local_s = pend_r;
            end
        end else begin
            grant_uart_s  = 1'b0;
            grant_local_s = 1'b0;
        end
        push_s       = frame_good_s && ((fifo_cnt_r != FULL_CNT) || grant_uart_s);
        drop_s       = frame_good_s && !push_s;
        lost_local_s = bus.local_valid_in && pend_r && !grant_local_s;
        err_inc_s    = {1'b0, parse_err_s} + {1'b0, drop_s} + {1'b0, lost_local_s};
        case ({push_s, grant_uart_s})
            2'b10:   fifo_cnt_s = fifo_cnt_r + CW'(1);
            2'b01:   fifo_cnt_s = fifo_cnt_r - CW'(1);
            default: fifo_cnt_s = fifo_cnt_r;
        endcase
    end

    // UART command FIFO storage and pointers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            wr_ptr_r    <= AW'(0);
            rd_ptr_r    <= AW'(0);
            fifo_cnt_r  <= CW'(0);
            fifo_full_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= cmd_latch_r;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (grant_uart_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            fifo_cnt_r  <= fifo_cnt_s;
            fifo_full_r <= (fifo_cnt_s == FULL_CNT);
        end
    end

    // Local pending slot; a newer strobe always replaces the held code.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_r     <= 1'b0;
            pend_cmd_r <= 8'h00;
        end else if (bus.local_valid_in) begin
            pend_r     <= 1'b1;
            pend_cmd_r <= bus.local_cmd_in;
        end else if (grant_local_s) begin
            pend_r <= 1'b0;
        end
    end

    // Output register, round-robin pointer and saturating error counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid_r <= 1'b0;
            out_cmd_r   <= 8'h00;
            out_src_r   <= 1'b0;
            rr_local_r  <= 1'b0;
            err_r       <= 8'h00;
        end else begin
            err_r <= err_add(err_r, err_inc_s);
            if (load_s) begin
                if (grant_uart_s) begin
                    out_valid_r <= 1'b1;
                    out_cmd_r   <= fifo_mem_r[rd_ptr_r];
                    out_src_r   <= 1'b0;
                    rr_local_r  <= 1'b1;
                end else if (grant_local_s) begin
                    out_valid_r <= 1'b1;
                    out_cmd_r   <= pend_cmd_r;
                    out_src_r   <= 1'b1;
                    rr_local_r  <= 1'b0;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

    assign bus.cmd_out       = out_cmd_r;
    assign bus.cmd_valid_out = out_valid_r;
    assign bus.src_out       = out_src_r;
    assign bus.fifo_full_out = fifo_full_r;
    assign bus.err_count_out = err_r;
endmodule

// File: tb/tb_input_cmd_arbiter.sv
// Self-checking bench for input_cmd_arbiter: frame vector table, directed corner sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_input_cmd_arbiter;
    localparam int TMO   = 40;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_cmd_arbiter_if bus ();

    input_cmd_arbiter #(
        .HDR_BYTE      (8'hA5),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_frame[$];
    int         m_idle;
    logic [7:0] m_q[$];
    bit         m_pend;
    logic [7:0] m_pcmd;
    bit         m_ov;
    logic [7:0] m_oc;
    bit         m_os;
    bit         m_pref_local;
    int         m_err;

    logic [7:0] got_cmd[$];
    bit         got_src[$];
    int         exp_err;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         exp_n;
        logic [7:0] exp_cmd;
        int         exp_err;
    } frame_vec_t;

    frame_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int errs;
        bit load, gu, gl;
        logic [7:0] d;
        if (rst) begin
            m_frame.delete(); m_q.delete();
            m_idle = 0; m_pend = 0; m_pcmd = 8'h00; m_ov = 0; m_oc = 8'h00;
            m_os = 0; m_pref_local = 0; m_err = 0;
            return;
        end
        errs = 0;
        load = !m_ov || bus.cmd_ready_in;
        gu = load && (m_q.size() > 0) && !(m_pend && m_pref_local);
        gl = load && m_pend && !gu;
        if (load) begin
            if (gu) begin
                m_ov = 1; m_oc = m_q.pop_front(); m_os = 0; m_pref_local = 1;
            end else if (gl) begin
                m_ov = 1; m_oc = m_pcmd; m_os = 1; m_pref_local = 0;
            end else begin
                m_ov = 0;
            end
        end
        d = bus.uart_data_in;
        if (bus.uart_valid_in) begin
            if (m_frame.size() == 0) begin
                if (d == 8'hA5) m_frame.push_back(d);
            end else if (m_frame.size() == 1) begin
                m_frame.push_back(d);
            end else begin
                if (d == (8'hA5 ^ m_frame[1])) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_frame[1]);
                    else errs++;
                end else begin
                    errs++;
                end
                m_frame.delete();
            end
            m_idle = 0;
        end else if (m_frame.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                errs++;
                m_frame.delete();
                m_idle = 0;
            end
        end
        if (bus.local_valid_in) begin
            if (m_pend && !gl) errs++;
            m_pend = 1;
            m_pcmd = bus.local_cmd_in;
        end else if (gl) begin
            m_pend = 0;
        end
        m_err = (m_err + errs > 255) ? 255 : m_err + errs;
    endtask

    task automatic tick();
        logic [31:0] act, exp;
        if (!rst && bus.cmd_valid_out && bus.cmd_ready_in) begin
            got_cmd.push_back(bus.cmd_out);
            got_src.push_back(bus.src_out);
        end
        @(posedge clk);
        model_step();
        #1;
        act = {13'd0, bus.cmd_valid_out, bus.cmd_valid_out ? bus.cmd_out : 8'h00,
               bus.cmd_valid_out & bus.src_out, bus.fifo_full_out, bus.err_count_out};
        exp = {13'd0, m_ov, m_ov ? m_oc : 8'h00, m_ov & m_os,
               m_q.size() == DEPTH, 8'(m_err)};
        check("model_cycle", act, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.uart_valid_in = 1'b1;
        bus.uart_data_in  = b;
        tick();
        bus.uart_valid_in = 1'b0;
    endtask

    task automatic send_local(input logic [7:0] c);
        bus.local_valid_in = 1'b1;
        bus.local_cmd_in   = c;
        tick();
        bus.local_valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input int gap);
        send_byte(8'hA5); idle(gap);
        send_byte(c);     idle(gap);
        send_byte(8'hA5 ^ c); idle(gap);
    endtask

    task automatic clear_got();
        got_cmd.delete();
        got_src.delete();
    endtask

    initial begin
        logic [7:0] t5_cmd[5];
        bit         t5_src[5];
        int         ph;
        logic [7:0] rc;
        bit         pause;

        vecs[0] = '{8'hA5, 8'h31, 8'h94, 1, 8'h31, 0};
        vecs[1] = '{8'hA5, 8'h31, 8'h00, 0, 8'h00, 1};
        vecs[2] = '{8'hA5, 8'h32, 8'h97, 1, 8'h32, 1};
        vecs[3] = '{8'h11, 8'h22, 8'h33, 0, 8'h00, 1};
        vecs[4] = '{8'hA5, 8'hA5, 8'h00, 1, 8'hA5, 1};
        vecs[5] = '{8'hA5, 8'hFF, 8'h5A, 1, 8'hFF, 1};
        vecs[6] = '{8'hA5, 8'h00, 8'hA5, 1, 8'h00, 1};
        vecs[7] = '{8'hA5, 8'h10, 8'hA5, 0, 8'h00, 2};
        t5_cmd = '{8'h60, 8'h7E, 8'h61, 8'h62, 8'h63};
        t5_src = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        bus.uart_valid_in = 1'b0; bus.uart_data_in = 8'h00;
        bus.local_valid_in = 1'b0; bus.local_cmd_in = 8'h00;
        bus.cmd_ready_in = 1'b0;
        rst = 1'b1;
        idle(2);
        check("reset_outputs", {bus.cmd_valid_out, bus.cmd_out, bus.src_out,
                                bus.fifo_full_out, bus.err_count_out}, 32'd0);
        rst = 1'b0;

        // frame vector table, ready held high, 10-cycle byte spacing
        bus.cmd_ready_in = 1'b1;
        for (int v = 0; v < 8; v++) begin
            clear_got();
            send_byte(vecs[v].b0); idle(9);
            send_byte(vecs[v].b1); idle(9);
            send_byte(vecs[v].b2); idle(6);
            check($sformatf("vec%0d_count", v), got_cmd.size(), vecs[v].exp_n);
            if (got_cmd.size() > 0) begin
                check($sformatf("vec%0d_cmd", v), got_cmd[0], vecs[v].exp_cmd);
                check($sformatf("vec%0d_src", v), got_src[0], 0);
            end
            check($sformatf("vec%0d_err", v), bus.err_count_out, vecs[v].exp_err);
        end
        exp_err = 2;

        // timeout after header, then orphan bytes are ignored
        clear_got();
        send_byte(8'hA5); idle(TMO + 5);
        exp_err++;
        check("tmo_err", bus.err_count_out, exp_err);
        send_byte(8'h31); idle(9); send_byte(8'h94); idle(5);
        check("tmo_orphan_none", got_cmd.size(), 0);
        check("tmo_orphan_err", bus.err_count_out, exp_err);
        // gaps one short of the timeout still make a frame
        clear_got();
        send_frame(8'h41, TMO - 1);
        idle(3);
        check("tmo_edge_count", got_cmd.size(), 1);
        if (got_cmd.size() > 0) check("tmo_edge_cmd", got_cmd[0], 8'h41);
        check("tmo_edge_err", bus.err_count_out, exp_err);

        // FIFO fill with consumer stalled, overflow drop, then drain in order
        bus.cmd_ready_in = 1'b0;
        clear_got();
        for (int k = 0; k < 5; k++) send_frame(8'h50 + 8'(k), 1);
        idle(2);
        check("fill_full", bus.fifo_full_out, 1);
        check("fill_err", bus.err_count_out, exp_err);
        send_frame(8'h55, 1);
        exp_err++;
        check("overflow_err", bus.err_count_out, exp_err);
        bus.cmd_ready_in = 1'b1;
        idle(10);
        check("drain_count", got_cmd.size(), 5);
        for (int k = 0; k < 5 && k < got_cmd.size(); k++)
            check($sformatf("drain_cmd%0d", k), got_cmd[k], 8'h50 + 8'(k));
        check("drain_not_full", bus.fifo_full_out, 0);

        // round robin between three queued UART commands and a pending local one
        bus.cmd_ready_in = 1'b0;
        for (int k = 0; k < 4; k++) send_frame(8'h60 + 8'(k), 1);
        send_local(8'h7E);
        idle(3);
        clear_got();
        bus.cmd_ready_in = 1'b1;
        idle(10);
        check("rr_count", got_cmd.size(), 5);
        for (int k = 0; k < 5 && k < got_cmd.size(); k++) begin
            check($sformatf("rr_cmd%0d", k), got_cmd[k], t5_cmd[k]);
            check($sformatf("rr_src%0d", k), got_src[k], t5_src[k]);
        end
        check("rr_err", bus.err_count_out, exp_err);

        // two local strobes into an empty output stage: 01 loads first, no error
        bus.cmd_ready_in = 1'b0;
        send_local(8'h01);
        send_local(8'h02);
        idle(3);
        check("loc_hold_cmd", bus.cmd_out, 8'h01);
        check("loc_hold_src", bus.src_out, 1);
        check("loc_noerr", bus.err_count_out, exp_err);
        clear_got();
        bus.cmd_ready_in = 1'b1;
        idle(4);
        check("loc_order_count", got_cmd.size(), 2);
        if (got_cmd.size() == 2) check("loc_order", {got_cmd[0], got_cmd[1]}, 16'h0102);

        // output stage busy: second strobe overwrites the pending one and counts an error
        bus.cmd_ready_in = 1'b0;
        send_local(8'h05);
        idle(3);
        send_local(8'h01);
        send_local(8'h02);
        idle(2);
        exp_err++;
        check("loc_overwrite_err", bus.err_count_out, exp_err);
        check("loc_busy_hold", bus.cmd_out, 8'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_reset", {bus.cmd_valid_out, bus.cmd_out, bus.src_out,
                               bus.fifo_full_out, bus.err_count_out}, 32'd0);

        // error counter saturation from continuous local overwrites
        send_local(8'h09);
        idle(2);
        bus.local_valid_in = 1'b1;
        for (int k = 0; k < 300; k++) begin
            bus.local_cmd_in = 8'(k);
            tick();
        end
        bus.local_valid_in = 1'b0;
        idle(1);
        check("err_saturate", bus.err_count_out, 8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // randomized traffic against the reference model
        ph = 0;
        rc = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            pause = (i % 600) > 540;
            bus.uart_valid_in = !pause && ($urandom_range(2, 0) == 0);
            if (bus.uart_valid_in) begin
                case (ph)
                    0: bus.uart_data_in = ($urandom_range(9, 0) != 0) ? 8'hA5 : 8'($urandom);
                    1: begin
                        rc = 8'($urandom);
                        bus.uart_data_in = rc;
                    end
                    default: bus.uart_data_in = ($urandom_range(7, 0) != 0) ? (8'hA5 ^ rc)
                                                                             : 8'($urandom);
                endcase
                ph = (ph == 2) ? 0 : ph + 1;
            end
            bus.local_valid_in = ($urandom_range(7, 0) == 0);
            bus.local_cmd_in   = 8'($urandom);
            bus.cmd_ready_in   = ((i % 800) < 400) ? ($urandom_range(3, 0) != 0)
                                                   : ($urandom_range(3, 0) == 0);
            rst = ($urandom_range(999, 0) == 0);
            tick();
        end
        rst = 1'b0;
        bus.uart_valid_in = 1'b0;
        bus.local_valid_in = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
